div_cu: RTL and testbench

- Control unit for the 4-bit restoring divider datapath `div_dp`. Sits directly upstream of it.
- Sequences load, shift, test/subtract and result-enable by driving every `div_dp` control input. Consumes the status outputs `R_lt_Y`, `cnt_out` and `error`.
- Top level ties `div_dp.n` to CNT_INIT. `div_dp` outputs q/r are valid while DONE=1.

---
 rtl/div_cu.sv | 128 ++++++++++++
 tb/tb_div_cu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/div_cu.sv
// div_cu: control sequencer for the 4-bit restoring divider datapath div_dp.
// Runs LOAD, CHECK, then CNT_INIT x (SHIFT, TEST), and ends in DONE or ERR.
module div_cu #(
  parameter int unsigned CNT_INIT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             GO,
  input  logic             R_lt_Y,
  input  logic [CNT_W-1:0] cnt_out,
  input  logic             error,
  output logic             udCE,
  output logic             udLD,
  output logic             udUD,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             rLD,
  output logic             rSL,
  output logic             rSR,
  output logic             xLD,
  output logic             xSL,
  output logic             xRightIn,
  output logic             yLD,
  output logic             DONE,
  output logic             ERR,
  output logic [2:0]       CS
);

  // The iteration counter must be able to hold its load value.
  if (CNT_INIT == 0 || CNT_INIT >= (64'd1 << CNT_W)) begin : g_bad_cnt_init
    $error("div_cu: CNT_INIT does not fit in CNT_W bits");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SHIFT = 3'd3,
    ST_TEST  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  assign CS = state;

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; TEST also looks at R_lt_Y.
  always_comb begin
    state_nxt = ST_IDLE;
    udCE      = 1'b0;
    udLD      = 1'b0;
    udUD      = 1'b0;
    s0        = 1'b0;
    s1        = 1'b0;
    s2        = 1'b0;
    rLD       = 1'b0;
    rSL       = 1'b0;
    rSR       = 1'b0;
    xLD       = 1'b0;
    xSL       = 1'b0;
    xRightIn  = 1'b0;
    yLD       = 1'b0;
    DONE      = 1'b0;
    ERR       = 1'b0;

    case (state)
      ST_IDLE: begin
        state_nxt = GO ? ST_LOAD : ST_IDLE;
      end

      ST_LOAD: begin
        xLD       = 1'b1;
        yLD       = 1'b1;
        rLD       = 1'b1;
        udLD      = 1'b1;
        state_nxt = ST_CHECK;
      end

      ST_CHECK: begin
        state_nxt = error ? ST_ERR : ST_SHIFT;
      end

      ST_SHIFT: begin
        rSL       = 1'b1;
        udCE      = 1'b1;
        state_nxt = ST_TEST;
      end

      ST_TEST: begin
        xSL       = 1'b1;
        xRightIn  = ~R_lt_Y;
        rLD       = ~R_lt_Y;
        s0        = ~R_lt_Y;
        state_nxt = (cnt_out == '0) ? ST_DONE : ST_SHIFT;
      end

      ST_DONE: begin
        s1        = 1'b1;
        s2        = 1'b1;
        DONE      = 1'b1;
        state_nxt = GO ? ST_DONE : ST_IDLE;
      end

      ST_ERR: begin
        ERR       = 1'b1;
        state_nxt = GO ? ST_ERR : ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_cu.sv
// tb_div_cu: drives div_cu against a behavioural div_dp model and checks
// state sequencing, latency and q/r against plain integer division.
module tb_div_cu;

  localparam int unsigned CNT_INIT = 4;
  localparam int unsigned CNT_W    = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             GO  = 1'b0;
  logic             R_lt_Y;
  logic [CNT_W-1:0] cnt_out;
  logic             error;
  logic             udCE, udLD, udUD, s0, s1, s2;
  logic             rLD, rSL, rSR, xLD, xSL, xRightIn, yLD;
  logic             DONE, ERR;
  logic [2:0]       CS;

  logic [3:0]       x_in = '0;
  logic [3:0]       y_in = '0;

  // Datapath state of the div_dp model.
  logic [4:0]       dp_r   = '0;
  logic [3:0]       dp_x   = '0;
  logic [3:0]       dp_y   = '0;
  logic [CNT_W-1:0] dp_cnt = '0;
  logic [3:0]       q_out;
  logic [3:0]       r_out;
  logic [15:0]      ctrl;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  bit          proto_on  = 1'b0;

  div_cu #(
    .CNT_INIT(CNT_INIT),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .GO      (GO),
    .R_lt_Y  (R_lt_Y),
    .cnt_out (cnt_out),
    .error   (error),
    .udCE    (udCE),
    .udLD    (udLD),
    .udUD    (udUD),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .rLD     (rLD),
    .rSL     (rSL),
    .rSR     (rSR),
    .xLD     (xLD),
    .xSL     (xSL),
    .xRightIn(xRightIn),
    .yLD     (yLD),
    .DONE    (DONE),
    .ERR     (ERR),
    .CS      (CS)
  );

  always #5 CLK = ~CLK;

  assign R_lt_Y  = (dp_r < {1'b0, dp_y});
  assign error   = (dp_y == 4'd0);
  assign cnt_out = dp_cnt;
  assign q_out   = s2 ? dp_x : 4'd0;
  assign r_out   = s1 ? dp_r[3:0] : 4'd0;
  assign ctrl    = {1'b0, udCE, udLD, udUD, s0, s1, s2, rLD, rSL, rSR,
                    xLD, xSL, xRightIn, yLD, DONE, ERR};

  // div_dp register behaviour under the unit's controls.
  always @(posedge CLK) begin
    if (rLD)      dp_r <= s0 ? (dp_r - {1'b0, dp_y}) : 5'd0;
    else if (rSL) dp_r <= {dp_r[3:0], dp_x[3]};
    if (xLD)      dp_x <= x_in;
    else if (xSL) dp_x <= {dp_x[2:0], xRightIn};
    if (yLD)      dp_y <= y_in;
    if (udLD)     dp_cnt <= CNT_INIT[CNT_W-1:0];
    else if (udCE) dp_cnt <= udUD ? dp_cnt + 1'b1 : dp_cnt - 1'b1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Control-legality checks on every cycle.
  always @(negedge CLK) begin
    if (proto_on) begin
      chk("rSR_low",   {15'd0, rSR},        16'd0);
      chk("udUD_low",  {15'd0, udUD},       16'd0);
      chk("r_excl",    {15'd0, rLD & rSL},  16'd0);
      chk("x_excl",    {15'd0, xLD & xSL},  16'd0);
    end
  end

  task automatic run_div(input logic [3:0] x, input logic [3:0] y, input int unsigned hold);
    logic [2:0]  exp_cs[$];
    logic [3:0]  q_e;
    logic [3:0]  r_e;
    int unsigned n_sub;
    int unsigned last;
    exp_cs = {3'd1, 3'd2};
    if (y == 4'd0) begin
      exp_cs.push_back(3'd6);
      q_e = 4'd0;
      r_e = 4'd0;
    end else begin
      repeat (CNT_INIT) begin
        exp_cs.push_back(3'd3);
        exp_cs.push_back(3'd4);
      end
      exp_cs.push_back(3'd5);
      q_e = x / y;
      r_e = x % y;
    end
    last  = exp_cs.size() - 1;
    n_sub = 0;

    @(negedge CLK);
    x_in = x;
    y_in = y;
    GO   = 1'b1;
    @(posedge CLK); #1;
    if (hold == 0) GO = 1'b0;

    for (int unsigned i = 0; i <= last; i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
      end
      chk($sformatf("cs[%0d] x=%0d y=%0d", i + 1, x, y), {13'd0, CS}, {13'd0, exp_cs[i]});
      chk($sformatf("done[%0d] x=%0d y=%0d", i + 1, x, y), {15'd0, DONE},
          {15'd0, (i == last) && (y != 4'd0)});
      chk($sformatf("err[%0d] x=%0d y=%0d", i + 1, x, y), {15'd0, ERR},
          {15'd0, (i == last) && (y == 4'd0)});
      if (CS == 3'd4 && rLD) n_sub++;
    end
    chk($sformatf("q x=%0d y=%0d", x, y), {12'd0, q_out}, {12'd0, q_e});
    chk($sformatf("r x=%0d y=%0d", x, y), {12'd0, r_out}, {12'd0, r_e});
    if (y != 4'd0)
      chk($sformatf("subs x=%0d y=%0d", x, y), n_sub[15:0], 16'($countones(q_e)));

    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk($sformatf("hold_cs x=%0d y=%0d", x, y), {13'd0, CS},
          (y == 4'd0) ? 16'd6 : 16'd5);
      chk($sformatf("hold_q x=%0d y=%0d", x, y), {12'd0, q_out}, {12'd0, q_e});
      chk($sformatf("hold_r x=%0d y=%0d", x, y), {12'd0, r_out}, {12'd0, r_e});
    end
    if (hold != 0) begin
      @(negedge CLK);
      GO = 1'b0;
    end
    @(posedge CLK); #1;
    chk("idle_cs",   {13'd0, CS}, 16'd0);
    chk("idle_ctrl", ctrl,        16'd0);
  endtask

  initial begin
    // Reset state.
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("reset_cs",   {13'd0, CS}, 16'd0);
    chk("reset_ctrl", ctrl,        16'd0);
    @(negedge CLK);
    RST      = 1'b0;
    proto_on = 1'b1;

    // Directed divisions, including all-subtract, no-subtract and divide-by-zero.
    run_div(4'd11, 4'd3, 0);
    run_div(4'd15, 4'd1, 0);
    run_div(4'd2,  4'd7, 0);
    run_div(4'd5,  4'd0, 0);

    // Reset during the second TEST state.
    @(negedge CLK);
    x_in = 4'd9;
    y_in = 4'd4;
    GO   = 1'b1;
    @(posedge CLK); #1;
    GO = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("mid_cs_test2", {13'd0, CS}, 16'd4);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("mid_reset_cs",   {13'd0, CS}, 16'd0);
    chk("mid_reset_ctrl", ctrl,        16'd0);
    @(negedge CLK);
    RST = 1'b0;
    run_div(4'd9, 4'd4, 0);

    // GO held through DONE / ERR, then a fresh division.
    run_div(4'd6,  4'd2, 5);
    run_div(4'd14, 4'd5, 0);
    run_div(4'd3,  4'd0, 2);
    run_div(4'd15, 4'd15, 0);
    run_div(4'd0,  4'd9, 0);

    // Random operands.
    for (int k = 0; k < 24; k++) begin
      run_div(4'($urandom_range(15)), 4'($urandom_range(15)), $urandom_range(2));
    end

    proto_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
